// File: rtl/dcache_scratch_responder.sv
// -----------------------------------------------------------------------------
// dcache_scratch_responder
//
// Memory-side responder for the D$ request interface driven by the MEM stage.
// The block accepts one load or store at a time. It services the request from
// an internal DEPTH_WORDS x 64-bit array after a fixed LATENCY.
//
// Stores merge only the addressed byte lanes. Loads return the whole aligned
// doubleword. Shifting, sign extension and stall decisions are left to the
// MEM stage. This serves as the D-side backing store until the real cache
// is in place.
//
// Ports
//   clk                clock
//   reset              synchronous, active-low reset
//   dc_en              request present; held high until the response
//   dc_in_addr         byte address; upper bits above the index alias
//   dc_write_en        1 = store, 0 = load
//   dc_in_wdata        store data, right-justified
//   dc_in_wlen         log2(bytes): 0=B 1=H 2=W 3=D
//   dc_out_rdata       aligned doubleword from the last completed load
//   dc_out_rvalid      one-cycle pulse: load complete
//   dc_out_write_done  one-cycle pulse: store committed
//   dc_busy            request in flight (WAIT state)
// -----------------------------------------------------------------------------
module dcache_scratch_responder #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dc_en,
  input  logic [ADDR_WIDTH-1:0] dc_in_addr,
  input  logic                  dc_write_en,
  input  logic [DATA_WIDTH-1:0] dc_in_wdata,
  input  logic [1:0]            dc_in_wlen,
  output logic [DATA_WIDTH-1:0] dc_out_rdata,
  output logic                  dc_out_rvalid,
  output logic                  dc_out_write_done,
  output logic                  dc_busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;

  // Request fields captured at accept time.
  logic [IDX_W-1:0]      req_index;
  logic [2:0]            req_offset;
  logic                  req_we;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [1:0]            req_wlen;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic                  latch_req;
  logic                  access;
  logic                  do_load;
  logic                  do_store;
  logic [IDX_W-1:0]      acc_index;
  logic [2:0]            acc_offset;
  logic                  acc_we;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [1:0]            acc_wlen;
  logic [15:0]           wide_mask;
  logic [LANES-1:0]      lane_mask;
  logic [DATA_WIDTH-1:0] shift_data;

  // Address bits above the index are deliberately ignored, so addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^dc_in_addr[ADDR_WIDTH-1:IDX_W+3];

  // With LATENCY==1 the access happens at the accept edge itself. The live
  // inputs feed the access in that case, because the latch has not yet been
  // updated. In every other case the access happens from WAIT and uses the
  // latched copy.
  always_comb begin
    if (state == ST_IDLE) begin
      acc_index  = dc_in_addr[3 +: IDX_W];
      acc_offset = dc_in_addr[2:0];
      acc_we     = dc_write_en;
      acc_wdata  = dc_in_wdata;
      acc_wlen   = dc_in_wlen;
    end else begin
      acc_index  = req_index;
      acc_offset = req_offset;
      acc_we     = req_we;
      acc_wdata  = req_wdata;
      acc_wlen   = req_wlen;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    latch_req  = 1'b0;
    access     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dc_en) begin
          latch_req = 1'b1;
          next_cnt  = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            access     = 1'b1;
            next_state = ST_RESP;
          end else begin
            next_state = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!dc_en) begin
          next_state = ST_IDLE;
        end else if (cnt == '0) begin
          access     = 1'b1;
          next_state = ST_RESP;
        end else begin
          next_cnt = cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        // dc_en still belongs to the completing instruction here.
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign do_load  = access & ~acc_we;
  assign do_store = access & acc_we;

  // Lanes that fall past byte 7 are shifted out of the 8-bit mask.
  // This drops them instead of wrapping them into the next word.
  assign wide_mask  = ((16'd1 << (5'd1 << acc_wlen)) - 16'd1) << acc_offset;
  assign lane_mask  = wide_mask[LANES-1:0];
  assign shift_data = acc_wdata << {acc_offset, 3'b000};

  assign dc_busy = (state == ST_WAIT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      dc_out_rvalid     <= 1'b0;
      dc_out_write_done <= 1'b0;
      dc_out_rdata      <= '0;
    end else begin
      state             <= next_state;
      cnt               <= next_cnt;
      dc_out_rvalid     <= do_load;
      dc_out_write_done <= do_store;
      if (do_load) begin
        dc_out_rdata <= mem[acc_index];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (latch_req) begin
      req_index  <= dc_in_addr[3 +: IDX_W];
      req_offset <= dc_in_addr[2:0];
      req_we     <= dc_write_en;
      req_wdata  <= dc_in_wdata;
      req_wlen   <= dc_in_wlen;
    end
  end

  // The array has no reset. A store is suppressed while reset is asserted,
  // so a request dropped by reset never reaches the array.
  always_ff @(posedge clk) begin
    if (reset && do_store) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_mask[i]) begin
          mem[acc_index][8*i +: 8] <= shift_data[8*i +: 8];
        end
      end
    end
  end

endmodule
